// File: rtl/imm_encoder.sv
// Immediate encoder: inserts a 32-bit immediate into the I/S/B/U/J fields of an
// instruction word through a 2-stage valid/ready pipeline. Optional macro IMM_RANGE_CHECK_EN.
module imm_encoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_base,
    input  logic [31:0]      in_imm,
    input  logic [2:0]       in_imm_type,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    logic        s1_valid;
    logic [31:0] s1_base;
    logic [31:0] s1_imm;
    logic [2:0]  s1_type;
    logic        s1_advance;
    logic [31:0] mask_c;
    logic [31:0] packed_c;
    logic        err_c;

    // Stage 1 may move on when the output register is empty or being consumed.
    assign s1_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;

    // Field mask and scattered immediate bits for the held request.
    always_comb begin
        mask_c   = 32'h0;
        packed_c = 32'h0;
        err_c    = 1'b0;
        case (s1_type)
            IMM_I: begin
                mask_c   = 32'hFFF0_0000;
                packed_c = {s1_imm[11:0], 20'h0};
            end
            IMM_S: begin
                mask_c   = 32'hFE00_0F80;
                packed_c = {s1_imm[11:5], 13'h0, s1_imm[4:0], 7'h0};
            end
            IMM_B: begin
                mask_c   = 32'hFE00_0F80;
                packed_c = {s1_imm[12], s1_imm[10:5], 13'h0, s1_imm[4:1], s1_imm[11], 7'h0};
            end
            IMM_U: begin
                mask_c   = 32'hFFFF_F000;
                packed_c = {s1_imm[31:12], 12'h0};
            end
            IMM_J: begin
                mask_c   = 32'hFFFF_F000;
                packed_c = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], 12'h0};
            end
            default: begin
                mask_c   = 32'h0;
                packed_c = 32'h0;
            end
        endcase
`ifdef IMM_RANGE_CHECK_EN
        case (s1_type)
            IMM_I, IMM_S: err_c = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
            IMM_B:        err_c = !((&s1_imm[31:12]) || !(|s1_imm[31:12])) || s1_imm[0];
            IMM_U:        err_c = |s1_imm[11:0];
            IMM_J:        err_c = !((&s1_imm[31:20]) || !(|s1_imm[31:20])) || s1_imm[0];
            default:      err_c = 1'b1;
        endcase
`endif
    end

    // Stage 1: capture request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_base  <= 32'h0;
            s1_imm   <= 32'h0;
            s1_type  <= 3'h0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_base <= in_base;
                s1_imm  <= in_imm;
                s1_type <= in_imm_type;
            end
        end
    end

    // Stage 2: merge and hold while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_inst  <= 32'h0;
            out_err   <= 1'b0;
        end else if (s1_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_inst <= (s1_base & ~mask_c) | packed_c;
                out_err  <= err_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (out_valid && out_ready) begin
            enc_count <= enc_count + CNT_W'(1);
            if (out_err) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed cases, backpressure, random
// streaming with round-trip decode, and mid-flight reset.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_base;
    logic [31:0] in_imm;
    logic [2:0]  in_imm_type;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    imm_encoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_base(in_base), .in_imm(in_imm), .in_imm_type(in_imm_type),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_err(out_err),
        .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [31:0] inst;
        logic        err;
        logic [31:0] imm;
        logic [2:0]  t;
        bit          legal;
    } exp_t;

    exp_t        q[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] enc_m = 0;
    logic [15:0] err_m = 0;
    bit          last_in_fire;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic bit is_legal(input logic [31:0] imm, input logic [2:0] t);
        longint s = longint'($signed(imm));
        case (t)
            3'd0, 3'd1: return s >= -2048 && s <= 2047;
            3'd2:       return s >= -4096 && s <= 4095 && (s % 2 == 0);
            3'd3:       return (imm % 4096) == 0;
            3'd4:       return s >= -(64'sd1 << 20) && s < (64'sd1 << 20) && (s % 2 == 0);
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] enc_model(input logic [31:0] b, input logic [31:0] imm,
                                              input logic [2:0] t);
        case (t)
            3'd0: return (b & 32'h000FFFFF) | ((imm & 32'hFFF) << 20);
            3'd1: return (b & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            3'd2: return (b & 32'h01FFF07F) | (((imm >> 12) & 32'h1) << 31)
                       | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8)
                       | (((imm >> 11) & 32'h1) << 7);
            3'd3: return (b & 32'hFFF) | (imm & 32'hFFFFF000);
            3'd4: return (b & 32'hFFF) | (((imm >> 20) & 32'h1) << 31)
                       | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20)
                       | (imm & 32'h000FF000);
            default: return b;
        endcase
    endfunction

    // The core's immediate generator, used for the round-trip check.
    function automatic logic [31:0] dec_model(input logic [31:0] i, input logic [2:0] t);
        case (t)
            3'd0: return {{20{i[31]}}, i[31:20]};
            3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3: return {i[31:12], 12'h0};
            3'd4: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return i;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [31:0] b, input logic [31:0] imm,
                         input logic [2:0] t);
        in_valid = v; in_base = b; in_imm = imm; in_imm_type = t;
        #1;
    endtask

    // Sample one cycle's handshakes (caller has let inputs settle), then advance.
    task automatic step();
        exp_t e;
        chk("enc_count", 32'(enc_count), 32'(enc_m));
        chk("err_count", 32'(err_count), 32'(err_m));
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_total++;
                $error("FAIL unexpected_output observed=%h expected=none", out_inst);
            end else begin
                e = q.pop_front();
                chk("out_inst", out_inst, e.inst);
                chk("out_err", 32'(out_err), 32'(e.err));
                if (e.legal) chk("round_trip", dec_model(out_inst, e.t), e.imm);
                enc_m = enc_m + 16'd1;
                if (e.err) err_m = err_m + 16'd1;
            end
        end
        last_in_fire = in_valid && in_ready;
        if (last_in_fire) begin
            e.inst  = enc_model(in_base, in_imm, in_imm_type);
            e.legal = is_legal(in_imm, in_imm_type);
            e.err   = CHK && !e.legal;
            e.imm   = in_imm;
            e.t     = in_imm_type;
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic directed(input string tag, input logic [31:0] b, input logic [31:0] imm,
                            input logic [2:0] t, input logic [31:0] xi, input logic xe);
        drive(1'b1, b, imm, t);
        step();
        drive(1'b0, 32'h0, 32'h0, 3'd0);
        step();
        chk({tag, "_valid"}, 32'(out_valid), 32'h1);
        chk({tag, "_inst"}, out_inst, xi);
        chk({tag, "_err"}, 32'(out_err), 32'(xe));
        step();
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] imm;
        logic [2:0]  t;
        logic [15:0] enc0;
        int          n;

        rst = 1'b1; out_ready = 1'b0;
        in_valid = 1'b0; in_base = 32'h0; in_imm = 32'h0; in_imm_type = 3'd0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_err", 32'(out_err), 32'h0);
        chk("rst_enc_count", 32'(enc_count), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;

        directed("dir_i",  32'h00000093, 32'hFFFFFFFF, 3'd0, 32'hFFF00093, 1'b0);
        directed("dir_b",  32'h00000063, 32'h00000FFE, 3'd2, 32'h7E000FE3, 1'b0);
        directed("dir_u",  32'h000000B7, 32'h12345000, 3'd3, 32'h123450B7, 1'b0);
        directed("dir_j",  32'h0000006F, 32'h00000800, 3'd4, 32'h0010006F, 1'b0);
        directed("dir_s",  32'h00002023, 32'hFFFFF804, 3'd1, 32'h80002223, 1'b0);
        directed("ovf_i",  32'h00000093, 32'h00000800, 3'd0, 32'h80000093, CHK);
        directed("odd_b",  32'h00000063, 32'h00000003, 3'd2, 32'h00000163, CHK);
        directed("bad_t",  32'hDEADBEEF, 32'h12345678, 3'd5, 32'hDEADBEEF, CHK);
        directed("bad_u",  32'h00000037, 32'h00000001, 3'd3, 32'h00000037, CHK);
        chk("err_count_dir", 32'(err_count), CHK ? 32'd4 : 32'd0);

        // Backpressure: two accepted, third stalls, held output stays stable.
        enc0 = enc_m;
        out_ready = 1'b0;
        drive(1'b1, 32'h00000013, 32'h00000001, 3'd0);
        step();
        drive(1'b1, 32'h00000013, 32'h00000002, 3'd0);
        step();
        drive(1'b1, 32'h00000013, 32'h00000003, 3'd0);
        for (int k = 0; k < 2; k++) begin
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_hold_inst", out_inst, q[0].inst);
            step();
            #1;
        end
        out_ready = 1'b1;
        #1;
        n = 0;
        do begin
            step();
            #1;
            n++;
        end while (!last_in_fire && n < 10);
        chk("bp_third_accepted", 32'(last_in_fire), 32'h1);
        drive(1'b0, 32'h0, 32'h0, 3'd0);
        n = 0;
        while (q.size() != 0 && n < 10) begin
            step();
            #1;
            n++;
        end
        chk("bp_drained", 32'(q.size()), 32'h0);
        chk("bp_enc_delta", 32'(enc_count - enc0), 32'd3);

        // Streaming: legal random requests back to back.
        for (int k = 0; k < 100; k++) begin
            r = $urandom;
            t = 3'($urandom_range(0, 4));
            case (t)
                3'd0, 3'd1: imm = {{20{r[11]}}, r[11:0]};
                3'd2:       imm = {{19{r[12]}}, r[12:1], 1'b0};
                3'd3:       imm = {r[31:12], 12'h0};
                default:    imm = {{11{r[20]}}, r[20:1], 1'b0};
            endcase
            drive(1'b1, $urandom, imm, t);
            chk("stream_in_ready", 32'(in_ready), 32'h1);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 3'd0);
        n = 0;
        while (q.size() != 0 && n < 10) begin
            step();
            #1;
            n++;
        end
        chk("stream_drained", 32'(q.size()), 32'h0);

        // Reset with two words in flight.
        out_ready = 1'b0;
        drive(1'b1, 32'h00000093, 32'h00000005, 3'd0);
        step();
        drive(1'b1, 32'h00000093, 32'h00000006, 3'd0);
        step();
        drive(1'b0, 32'h0, 32'h0, 3'd0);
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'h0);
        chk("rst_mid_enc", 32'(enc_count), 32'h0);
        chk("rst_mid_err", 32'(err_count), 32'h0);
        q.delete();
        enc_m = 0;
        err_m = 0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("post_rst_valid", 32'(out_valid), 32'h0);
            step();
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
